mem_dump_reader: RTL and testbench
==================================

Name: mem_dump_reader

Overview:
- Hardware readback engine for the mips_32 data memory.
- After a start pulse, it reads a contiguous window of data-memory words through a synchronous read port and streams each word out with valid/ready handshaking.
- It is the reader counterpart to the preload/store path that writes data memory.
- It sits beside data_mem, muxed onto its read port when the core is idle, and lets result regions such as words 11..32 be dumped on hardware without hierarchical peeking.

Parameters:
- ADDR_W, 6, word-address width of data memory (2^ADDR_W words, wraps modulo 2^ADDR_W)
- DATA_W, 32, data word width

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; forces IDLE and zeroes all registered outputs
- start  input  1  request a dump; sampled only in IDLE
- base_addr  input  ADDR_W  first word address, latched on accepted start
- word_count  input  ADDR_W+1  number of words to dump (0..2^ADDR_W), latched on accepted start
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the dump completes
- mem_rd_en  output  1  read strobe to data memory
- mem_addr  output  ADDR_W  read address
- mem_rd_data  input  DATA_W  read data, valid exactly one cycle after mem_rd_en
- out_valid  output  1  out_data/out_addr hold a word
- out_ready  input  1  downstream accepts the word
- out_data  output  DATA_W  dumped word (registered)
- out_addr  output  ADDR_W  address of out_data (registered)

Behaviour:
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, out_valid=0, out_data=0, out_addr=0.
- Reset also clears the internal address and remaining count. Reset asserted mid-dump aborts immediately: no done pulse, and the next cycle is IDLE.
- FSM states: IDLE, READ, WAIT, HOLD, DONE.
- IDLE:
  - start=1 latches base_addr into cur_addr and word_count into remaining.
  - If word_count=0, go to DONE; otherwise go to READ.
- READ: mem_rd_en=1, mem_addr=cur_addr; go to WAIT.
- WAIT:
  - mem_rd_en=0.
  - Register mem_rd_data into out_data and cur_addr into out_addr at the end of this cycle; go to HOLD.
- HOLD:
  - out_valid=1. out_data and out_addr are stable while out_ready=0, with no further reads issued.
  - On out_valid&&out_ready with remaining=1: go to DONE.
  - On the same handshake otherwise: decrement remaining, cur_addr=cur_addr+1 (mod 2^ADDR_W), go to READ.
  - out_valid drops the cycle after the handshake.
- DONE: done=1 for exactly one cycle; go to IDLE.
- Timing with out_ready held 1 and start sampled at cycle 0:
  - Word k is valid in cycle 3+3k.
  - done is high in cycle 3n+1 for n words.
  - For word_count=0, done is high in cycle 1.
- start while busy is ignored and never queued. start in the same cycle as reset is ignored.
- A word_count of 2^ADDR_W dumps the entire memory starting at base_addr, wrapping.
- mem_rd_en is asserted exactly once per word.

Optional Feature:
- Macro: MEM_DUMP_CHECKSUM_EN.
- When defined:
  - Adds output port checksum [DATA_W-1:0], a running sum modulo 2^DATA_W of every word accepted on the output handshake.
  - checksum clears to 0 on accepted start and on reset.
  - checksum holds its final value after done until the next accepted start.
- When undefined, the port and the accumulator are absent; all other behaviour is identical.

Test Plan:
- Zero-latency sink:
  - Stimulus: ram[0..2]=00000001,0fd76e10,5a00429b; start with base=0, count=3, out_ready=1.
  - Response: out_valid in cycles 3,6,9 with out_data 00000001,0fd76e10,5a00429b and out_addr 0,1,2; done in cycle 10; checksum=69d7b0ac when enabled.
- Backpressure:
  - Stimulus: base=1, count=2; out_ready=0 for 5 cycles after the first out_valid.
  - Response: out_data=0fd76e10 and out_addr=1 stable and mem_rd_en=0 throughout; the second word 5a00429b appears 3 cycles after out_ready rises.
- Wrap-around:
  - Stimulus: ram[63]=c187a606, ram[0]=00000001; base=63, count=2.
  - Response: out_addr 63 then 0, out_data c187a606 then 00000001.
- Zero count:
  - Stimulus: base=5, count=0.
  - Response: done in cycle 1, mem_rd_en and out_valid never asserted.
- Start while busy:
  - Stimulus: a second start with base=20 during a base=0, count=3 dump.
  - Response: only addresses 0,1,2 are dumped and a single done pulse occurs.
- Reset mid-dump:
  - Stimulus: assert reset during HOLD of the second word.
  - Response: next cycle busy=0, out_valid=0, out_data=0, no done pulse; a new start then dumps correctly from its base_addr.

Source files
------------

// File: rtl/mem_dump_reader.sv
// Readback engine: streams a contiguous window of data memory out over valid/ready.
// Optional running checksum of accepted words is enabled by defining MEM_DUMP_CHECKSUM_EN.
module mem_dump_reader #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr
`ifdef MEM_DUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        HOLD,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   remaining;

    logic handshake_c;
    logic last_word_c;

    assign handshake_c = out_valid && out_ready;
    assign last_word_c = (remaining == (ADDR_W+1)'(1));

    // Control FSM; every output is updated here so all of them are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cur_addr  <= base_addr;
                        remaining <= word_count;
                        busy      <= 1'b1;
                        if (word_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= READ;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= base_addr;
                        end
                    end
                end

                READ: begin
                    mem_rd_en <= 1'b0;
                    state     <= WAIT;
                end

                // Read data returns this cycle; capture it with its address.
                WAIT: begin
                    out_data  <= mem_rd_data;
                    out_addr  <= cur_addr;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end

                HOLD: begin
                    if (handshake_c) begin
                        out_valid <= 1'b0;
                        if (last_word_c) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            remaining <= remaining - (ADDR_W+1)'(1);
                            cur_addr  <= cur_addr + ADDR_W'(1);
                            mem_rd_en <= 1'b1;
                            mem_addr  <= cur_addr + ADDR_W'(1);
                            state     <= READ;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    mem_rd_en <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_DUMP_CHECKSUM_EN
    // Running sum of accepted words; held after done until the next accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (state == HOLD && handshake_c) begin
            checksum <= checksum + out_data;
        end
    end
`endif

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed self-checking bench for mem_dump_reader with a synchronous-read memory model.
module tb_mem_dump_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  base_addr;
    logic [6:0]  word_count;
    logic        busy;
    logic        done;
    logic        mem_rd_en;
    logic [5:0]  mem_addr;
    logic [31:0] mem_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_addr;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] ram [64];
    int          checks;
    int          failures;
    int          done_cnt;
    int          done_before;

    mem_dump_reader #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_addr    (out_addr)
`ifdef MEM_DUMP_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    end

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one dump with out_ready held high; optionally pokes start while busy.
    task automatic dump(input logic [5:0] base, input logic [6:0] cnt, input bit busy_start);
        logic [5:0] a;
        start      = 1'b1;
        base_addr  = base;
        word_count = cnt;
        tick();
        start = 1'b0;
        if (cnt == 7'd0) begin
            check("zero_done", 32'(done), 32'd1);
            check("zero_busy", 32'(busy), 32'd1);
            check("zero_rd_en", 32'(mem_rd_en), 32'd0);
            check("zero_valid", 32'(out_valid), 32'd0);
            tick();
            check("zero_done_drop", 32'(done), 32'd0);
            check("zero_idle", 32'(busy), 32'd0);
            check("zero_rd_en2", 32'(mem_rd_en), 32'd0);
            return;
        end
        for (int k = 0; k < int'(cnt); k++) begin
            a = base + 6'(k);
            check("rd_en", 32'(mem_rd_en), 32'd1);
            check("rd_addr", 32'(mem_addr), 32'(a));
            check("busy", 32'(busy), 32'd1);
            if (busy_start && k == 0) begin
                start     = 1'b1;
                base_addr = 6'd20;
            end
            tick();
            start = 1'b0;
            check("wait_rd_en", 32'(mem_rd_en), 32'd0);
            check("wait_valid", 32'(out_valid), 32'd0);
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", out_data, ram[a]);
            check("hold_addr", 32'(out_addr), 32'(a));
            check("hold_done", 32'(done), 32'd0);
            tick();
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_valid", 32'(out_valid), 32'd0);
        tick();
        check("done_drop", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        clk        = 1'b0;
        checks     = 0;
        failures   = 0;
        done_cnt   = 0;
        reset      = 1'b1;
        start      = 1'b1;
        base_addr  = 6'd7;
        word_count = 7'd4;
        out_ready  = 1'b1;
        for (int i = 0; i < 64; i++) ram[i] = 32'hA5000000 | 32'(i);
        ram[0]  = 32'h00000001;
        ram[1]  = 32'h0fd76e10;
        ram[2]  = 32'h5a00429b;
        ram[63] = 32'hc187a606;
        ram[10] = 32'h12345678;
        ram[11] = 32'h9abcdef0;

        // Reset with start asserted: start is ignored.
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_addr", 32'(out_addr), 32'd0);
`ifdef MEM_DUMP_CHECKSUM_EN
        check("rst_checksum", checksum, 32'd0);
`endif
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("post_rst_idle", 32'(busy), 32'd0);

        // Zero-latency sink.
        done_before = done_cnt;
        dump(6'd0, 7'd3, 1'b0);
        check("t1_done_count", 32'(done_cnt - done_before), 32'd1);
`ifdef MEM_DUMP_CHECKSUM_EN
        check("t1_checksum", checksum, 32'h69d7b0ac);
        tick();
        check("t1_checksum_hold", checksum, 32'h69d7b0ac);
`endif

        // Backpressure: hold the first word for five cycles.
        start      = 1'b1;
        base_addr  = 6'd1;
        word_count = 7'd2;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("bp_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", out_data, 32'h0fd76e10);
            check("bp_hold_addr", 32'(out_addr), 32'd1);
            check("bp_no_read", 32'(mem_rd_en), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_released", 32'(out_valid), 32'd0);
        check("bp_next_read", 32'(mem_rd_en), 32'd1);
        tick();
        check("bp_wait", 32'(out_valid), 32'd0);
        tick();
        check("bp_w2_valid", 32'(out_valid), 32'd1);
        check("bp_w2_data", out_data, 32'h5a00429b);
        check("bp_w2_addr", 32'(out_addr), 32'd2);
        tick();
        check("bp_done", 32'(done), 32'd1);
`ifdef MEM_DUMP_CHECKSUM_EN
        check("bp_checksum", checksum, 32'h69d7b0ab);
`endif
        tick();

        // Wrap-around from the top word.
        dump(6'd63, 7'd2, 1'b0);

        // Zero count.
        done_before = done_cnt;
        dump(6'd5, 7'd0, 1'b0);
        check("zero_done_count", 32'(done_cnt - done_before), 32'd1);

        // Start while busy is ignored.
        done_before = done_cnt;
        dump(6'd0, 7'd3, 1'b1);
        tick();
        tick();
        check("busy_start_idle", 32'(busy), 32'd0);
        check("busy_start_no_read", 32'(mem_rd_en), 32'd0);
        check("busy_start_done_count", 32'(done_cnt - done_before), 32'd1);

        // Reset during HOLD of the second word.
        done_before = done_cnt;
        start      = 1'b1;
        base_addr  = 6'd0;
        word_count = 7'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid_hold_w2", 32'(out_addr), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        tick();
        check("mid_rst_stay_idle", 32'(busy), 32'd0);
        check("mid_rst_no_done", 32'(done_cnt - done_before), 32'd0);
        dump(6'd10, 7'd2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
